// File: rtl/score_tracker.sv
// Score statistics for the scoreboard display: combo, base/bonus score, and
// accuracy/level from an iterative restoring divider that runs after each hit.
module score_tracker #(
    parameter int SCORE_W   = 21,
    parameter int CNT_W     = 16,
    parameter int BONUS_CAP = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               hit_valid,
    input  logic [1:0]         hit_grade,
    input  logic [3:0]         difficulty,
    input  logic [1:0]         mod,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo,
    output logic [SCORE_W-1:0] base_score,
    output logic [SCORE_W-1:0] bonus_score,
    output logic [SCORE_W-1:0] acc,
    output logic [2:0]         level,
    output logic               busy
);

    localparam int NUM_W = 31;
    localparam int DEN_W = CNT_W + 2;
    localparam logic [SCORE_W-1:0] SAT = '1;
    localparam logic [SCORE_W-1:0] CAP = SCORE_W'(BONUS_CAP);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SCORE_W-1:0] r_combo;
    logic [SCORE_W-1:0] r_max_combo;
    logic [SCORE_W-1:0] r_base;
    logic [SCORE_W-1:0] r_bonus;
    logic [SCORE_W-1:0] r_acc;
    logic [2:0]         r_level;
    logic [CNT_W-1:0]   r_notes;
    logic [CNT_W+1:0]   r_wsum;
    logic [NUM_W-1:0]   r_quo;
    logic [DEN_W-1:0]   r_rem;
    logic [DEN_W-1:0]   r_den;
    logic [4:0]         r_cnt;
    logic               r_pending;

    logic               w_hit;
    logic [8:0]         w_points;
    logic [12:0]        w_base_inc;
    logic [SCORE_W:0]   w_base_sum;
    logic [SCORE_W-1:0] w_base_next;
    logic [SCORE_W-1:0] w_combo_inc;
    logic [SCORE_W-1:0] w_capped;
    logic [SCORE_W+1:0] w_bonus_inc;
    logic [SCORE_W+2:0] w_bonus_sum;
    logic [SCORE_W-1:0] w_bonus_next;
    logic [NUM_W-1:0]   w_num;
    logic [DEN_W-1:0]   w_den;
    logic [DEN_W:0]     w_trial;
    logic               w_ge;
    logic [DEN_W:0]     w_diff;
    logic [SCORE_W-1:0] w_acc_new;
    logic [2:0]         w_level_new;

    assign w_hit = hit_valid & en & ~start;

    always_comb begin
        w_points = 9'd0;
        case (hit_grade)
            2'd3:    w_points = 9'd300;
            2'd2:    w_points = 9'd200;
            2'd1:    w_points = 9'd100;
            default: w_points = 9'd0;
        endcase
    end

    // Score paths are widened by the carry bits so saturation can be detected.
    assign w_base_inc  = 13'(w_points) * 13'({1'b0, difficulty} + 5'd1);
    assign w_base_sum  = {1'b0, r_base} + (SCORE_W+1)'(w_base_inc);
    assign w_base_next = w_base_sum[SCORE_W] ? SAT : w_base_sum[SCORE_W-1:0];

    assign w_combo_inc  = (r_combo == SAT) ? SAT : r_combo + 1'b1;
    assign w_capped     = (w_combo_inc > CAP) ? CAP : w_combo_inc;
    assign w_bonus_inc  = (SCORE_W+2)'(w_capped) * (SCORE_W+2)'({1'b0, mod} + 3'd1);
    assign w_bonus_sum  = (SCORE_W+3)'(r_bonus) + (SCORE_W+3)'(w_bonus_inc);
    assign w_bonus_next = (w_bonus_sum[SCORE_W+2:SCORE_W] != 3'd0) ? SAT
                                                                   : w_bonus_sum[SCORE_W-1:0];

    assign w_num = NUM_W'(r_wsum) * NUM_W'(10000);
    assign w_den = (DEN_W'(r_notes) << 1) + DEN_W'(r_notes);

    // One restoring step: the numerator shifts out of r_quo as quotient bits shift in.
    assign w_trial = {r_rem, r_quo[NUM_W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_den});
    assign w_diff  = w_trial - {1'b0, r_den};

    assign w_acc_new = SCORE_W'(r_quo);

    always_comb begin
        w_level_new = 3'd0;
        if (w_acc_new == SCORE_W'(10000))     w_level_new = 3'd6;
        else if (w_acc_new >= SCORE_W'(9500)) w_level_new = 3'd5;
        else if (w_acc_new >= SCORE_W'(9000)) w_level_new = 3'd4;
        else if (w_acc_new >= SCORE_W'(8000)) w_level_new = 3'd3;
        else if (w_acc_new >= SCORE_W'(7000)) w_level_new = 3'd2;
        else if (w_acc_new >= SCORE_W'(6000)) w_level_new = 3'd1;
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_hit) w_state_next = S_LOAD;
                S_LOAD: w_state_next = S_DIV;
                S_DIV:  if (r_cnt == 5'd30) w_state_next = S_DONE;
                S_DONE: w_state_next = (r_pending | w_hit) ? S_LOAD : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_base      <= '0;
            r_bonus     <= '0;
            r_acc       <= '0;
            r_level     <= '0;
            r_notes     <= '0;
            r_wsum      <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_den       <= '0;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
        end else if (start) begin
            r_state     <= S_IDLE;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_base      <= '0;
            r_bonus     <= '0;
            r_acc       <= '0;
            r_level     <= '0;
            r_notes     <= '0;
            r_wsum      <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_den       <= '0;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_hit) begin
                r_base <= w_base_next;
                if (hit_grade == 2'd0) begin
                    r_combo <= '0;
                end else begin
                    r_combo <= w_combo_inc;
                    r_bonus <= w_bonus_next;
                    if (w_combo_inc > r_max_combo) r_max_combo <= w_combo_inc;
                end
                if (r_notes != {CNT_W{1'b1}}) begin
                    r_notes <= r_notes + 1'b1;
                    r_wsum  <= r_wsum + (CNT_W+2)'(hit_grade);
                end
            end

            // DONE consumes the pending request itself by looping back to LOAD.
            if (r_state == S_DONE)
                r_pending <= 1'b0;
            else if (w_hit && r_state != S_IDLE)
                r_pending <= 1'b1;

            case (r_state)
                S_LOAD: begin
                    r_quo <= w_num;
                    r_den <= w_den;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff[DEN_W-1:0] : w_trial[DEN_W-1:0];
                    r_quo <= {r_quo[NUM_W-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_acc   <= w_acc_new;
                    r_level <= w_level_new;
                end
                default: ;
            endcase
        end
    end

    assign combo       = r_combo;
    assign max_combo   = r_max_combo;
    assign base_score  = r_base;
    assign bonus_score = r_bonus;
    assign acc         = r_acc;
    assign level       = r_level;
    assign busy        = (r_state != S_IDLE);

endmodule
